// File: rtl/n64_link_sequencer_if.sv
// N64 link sequencer bus: line sample, receiver/transmitter
// handoffs, and the sequencer's direction/status outputs.
interface n64_link_sequencer_if;
  logic       data_rx;
  logic       tx_handoff;
  logic [7:0] cmd;
  logic       rx_handoff;
  logic       cur_operation;
  logic       tx_start;
  logic       rx_timeout;
  logic       tx_timeout;
  logic       bad_cmd;
  logic [2:0] state;
  logic [7:0] xfer_count;

  modport master (
    output data_rx,
    output tx_handoff,
    output cmd,
    output rx_handoff,
    input  cur_operation,
    input  tx_start,
    input  rx_timeout,
    input  tx_timeout,
    input  bad_cmd,
    input  state,
    input  xfer_count
  );

  modport slave (
    input  data_rx,
    input  tx_handoff,
    input  cmd,
    input  rx_handoff,
    output cur_operation,
    output tx_start,
    output rx_timeout,
    output tx_timeout,
    output bad_cmd,
    output state,
    output xfer_count
  );
endinterface

// File: rtl/n64_link_sequencer.sv
// N64 half-duplex link sequencer: idle qualification, receive,
// turnaround and transmit phases with timeouts and a transfer count.
module n64_link_sequencer #(
  parameter int IDLE_CYCLES       = 8,
  parameter int TURNAROUND_CYCLES = 4,
  parameter int RX_TIMEOUT        = 1024,
  parameter int TX_TIMEOUT        = 1024
) (
  input  logic               sample_clk,
  input  logic               rst_n,
  n64_link_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_SYNC     = 3'd0,
    S_LISTEN   = 3'd1,
    S_RECEIVE  = 3'd2,
    S_TURN     = 3'd3,
    S_TRANSMIT = 3'd4
  } state_t;

  localparam logic [15:0] LP_IDLE = 16'(IDLE_CYCLES);
  localparam logic [15:0] LP_TA   = 16'(TURNAROUND_CYCLES);
  localparam logic [15:0] LP_RXTO = 16'(RX_TIMEOUT);
  localparam logic [15:0] LP_TXTO = 16'(TX_TIMEOUT);

  state_t      r_state, w_state_nx;
  logic [15:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [15:0] r_tmo, w_tmo_nx, w_tmo_inc;
  logic [7:0]  r_xfer, w_xfer_nx;
  logic        r_cop, w_cop_nx;
  logic        r_txs, w_txs_nx;
  logic        r_rxt, w_rxt_nx;
  logic        r_txt, w_txt_nx;
  logic        r_bad, w_bad_nx;
  logic        w_cmd_ok;

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_tmo_inc = (r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 16'd1;

  assign w_cmd_ok = bus.cmd inside {8'h00, 8'h01, 8'hFF, 8'h02, 8'h03};

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_tmo_nx   = r_tmo;
    w_xfer_nx  = r_xfer;
    w_txs_nx   = 1'b0;
    w_rxt_nx   = 1'b0;
    w_txt_nx   = 1'b0;
    w_bad_nx   = 1'b0;
    case (r_state)
      S_SYNC: begin
        if (!bus.data_rx) begin
          w_cnt_nx = '0;
        end else if (w_cnt_inc >= LP_IDLE) begin
          w_state_nx = S_LISTEN;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_LISTEN: begin
        if (!bus.data_rx) begin
          w_state_nx = S_RECEIVE;
          w_tmo_nx   = '0;
        end
      end
      S_RECEIVE: begin
        w_tmo_nx = w_tmo_inc;
        // A handoff landing on the timeout cycle still wins.
        if (bus.tx_handoff) begin
          if (w_cmd_ok) begin
            w_state_nx = S_TURN;
          end else begin
            w_state_nx = S_SYNC;
            w_bad_nx   = 1'b1;
          end
        end else if (w_tmo_inc >= LP_RXTO) begin
          w_state_nx = S_SYNC;
          w_rxt_nx   = 1'b1;
        end
      end
      S_TURN: begin
        if (w_cnt_inc >= LP_TA) begin
          w_state_nx = S_TRANSMIT;
          w_tmo_nx   = '0;
          w_txs_nx   = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_TRANSMIT: begin
        w_tmo_nx = w_tmo_inc;
        if (bus.rx_handoff) begin
          w_state_nx = S_SYNC;
          w_xfer_nx  = r_xfer + 8'd1;
        end else if (w_tmo_inc >= LP_TXTO) begin
          w_state_nx = S_SYNC;
          w_txt_nx   = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_SYNC;
      end
    endcase
    // Each phase starts its own count from zero.
    if (w_state_nx != r_state) w_cnt_nx = '0;
    w_cop_nx = (w_state_nx == S_TRANSMIT);
  end

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SYNC;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_xfer  <= '0;
      r_cop   <= 1'b0;
      r_txs   <= 1'b0;
      r_rxt   <= 1'b0;
      r_txt   <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_tmo   <= w_tmo_nx;
      r_xfer  <= w_xfer_nx;
      r_cop   <= w_cop_nx;
      r_txs   <= w_txs_nx;
      r_rxt   <= w_rxt_nx;
      r_txt   <= w_txt_nx;
      r_bad   <= w_bad_nx;
    end
  end

  assign bus.state         = r_state;
  assign bus.cur_operation = r_cop;
  assign bus.tx_start      = r_txs;
  assign bus.rx_timeout    = r_rxt;
  assign bus.tx_timeout    = r_txt;
  assign bus.bad_cmd       = r_bad;
  assign bus.xfer_count    = r_xfer;

endmodule

// File: tb/tb_n64_link_sequencer.sv
// Directed bench for n64_link_sequencer with an expected-output
// queue filled at drive time and drained after each clock edge.
module tb_n64_link_sequencer;

  localparam logic [2:0] SY = 3'd0;
  localparam logic [2:0] LI = 3'd1;
  localparam logic [2:0] RX = 3'd2;
  localparam logic [2:0] TA = 3'd3;
  localparam logic [2:0] TX = 3'd4;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  logic sample_clk;
  logic rst_n;
  exp_t q[$];
  int   n_total;
  int   n_pass;
  logic [7:0] m_xfer;

  n64_link_sequencer_if bus ();

  n64_link_sequencer dut (
    .sample_clk (sample_clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
  );

  initial sample_clk = 1'b0;
  always #5 sample_clk = ~sample_clk;

  function automatic logic [15:0] obs();
    return {bus.state, bus.cur_operation, bus.tx_start,
            bus.rx_timeout, bus.tx_timeout, bus.bad_cmd,
            bus.xfer_count};
  endfunction

  function automatic logic [15:0] ev(
    logic [2:0] s, logic cop = 1'b0, logic txs = 1'b0,
    logic rxt = 1'b0, logic txt = 1'b0, logic bad = 1'b0);
    return {s, cop, txs, rxt, txt, bad, m_xfer};
  endfunction

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step(input string tag, input logic [15:0] exp);
    exp_t e;
    q.push_back('{tag, exp});
    @(posedge sample_clk);
    #1;
    e = q.pop_front();
    check(e.tag, obs(), e.v);
  endtask

  task automatic go_listen();
    bus.data_rx = 1'b0;
    step("sync_clr", ev(SY));
    bus.data_rx = 1'b1;
    for (int i = 0; i < 7; i++) step("sync_cnt", ev(SY));
    step("listen", ev(LI));
  endtask

  task automatic to_receive();
    go_listen();
    bus.data_rx = 1'b0;
    step("rx_enter", ev(RX));
    bus.data_rx = 1'b1;
  endtask

  task automatic to_transmit(input logic [7:0] c);
    to_receive();
    bus.tx_handoff = 1'b1;
    bus.cmd = c;
    step("hand_ok", ev(TA));
    bus.tx_handoff = 1'b0;
    for (int i = 0; i < 3; i++) step("turn", ev(TA));
    step("tx_entry", ev(TX, 1'b1, 1'b1));
  endtask

  initial begin
    logic [7:0] cmds [5];
    n_total = 0;
    n_pass  = 0;
    m_xfer  = 8'd0;
    cmds[0] = 8'h00;
    cmds[1] = 8'h01;
    cmds[2] = 8'hFF;
    cmds[3] = 8'h02;
    cmds[4] = 8'h03;
    rst_n = 1'b0;
    bus.data_rx = 1'b1;
    bus.tx_handoff = 1'b0;
    bus.cmd = 8'h00;
    bus.rx_handoff = 1'b0;
    #12;
    check("reset", obs(), ev(SY));
    @(negedge sample_clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) step("idle_pre", ev(SY));
    bus.data_rx = 1'b0;
    step("idle_break", ev(SY));
    bus.data_rx = 1'b1;
    for (int i = 0; i < 7; i++) step("idle_cnt", ev(SY));
    step("idle_done", ev(LI));

    bus.tx_handoff = 1'b1;
    bus.cmd = 8'h01;
    step("listen_ign_tx", ev(LI));
    bus.tx_handoff = 1'b0;
    bus.data_rx = 1'b0;
    bus.rx_handoff = 1'b1;
    step("rx_enter", ev(RX));
    bus.rx_handoff = 1'b0;
    for (int i = 0; i < 39; i++) begin
      bus.data_rx = 1'($urandom_range(0, 1));
      step("rx_wait", ev(RX));
    end
    bus.tx_handoff = 1'b1;
    bus.cmd = 8'h01;
    step("hand_01", ev(TA));
    bus.tx_handoff = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data_rx = 1'($urandom_range(0, 1));
      step("turn_hold", ev(TA));
    end
    step("tx_entry", ev(TX, 1'b1, 1'b1));
    step("tx_start_1cyc", ev(TX, 1'b1));
    for (int i = 0; i < 98; i++) begin
      bus.data_rx = 1'($urandom_range(0, 1));
      bus.tx_handoff = (i == 5);
      step("tx_hold", ev(TX, 1'b1));
    end
    bus.tx_handoff = 1'b0;
    bus.rx_handoff = 1'b1;
    m_xfer++;
    step("rx_hand", ev(SY));
    bus.rx_handoff = 1'b0;
    bus.data_rx = 1'b0;
    step("sync_after", ev(SY));

    for (int n = 0; n < 255; n++) begin
      to_transmit(cmds[n % 5]);
      bus.rx_handoff = 1'b1;
      m_xfer++;
      step("xfer_done", ev(SY));
      bus.rx_handoff = 1'b0;
    end
    check("xfer_wrap", {8'd0, bus.xfer_count}, 16'd0);

    to_receive();
    for (int i = 0; i < 1023; i++) step("rx_tmo_wait", ev(RX));
    step("rx_timeout", ev(SY, 1'b0, 1'b0, 1'b1));
    step("rx_to_1cyc", ev(SY));

    to_receive();
    bus.tx_handoff = 1'b1;
    bus.cmd = 8'h55;
    step("bad_cmd", ev(SY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    bus.tx_handoff = 1'b0;
    step("bad_1cyc", ev(SY));

    to_receive();
    for (int i = 0; i < 1023; i++) step("rx_tie_wait", ev(RX));
    bus.tx_handoff = 1'b1;
    bus.cmd = 8'hFF;
    step("rx_to_tie", ev(TA));
    bus.tx_handoff = 1'b0;
    for (int i = 0; i < 3; i++) step("turn", ev(TA));
    step("tx_entry", ev(TX, 1'b1, 1'b1));
    for (int i = 0; i < 1023; i++) step("tx_tie_wait", ev(TX, 1'b1));
    bus.rx_handoff = 1'b1;
    m_xfer++;
    step("tx_to_tie", ev(SY));
    bus.rx_handoff = 1'b0;

    to_transmit(8'h03);
    for (int i = 0; i < 1023; i++) step("tx_tmo_wait", ev(TX, 1'b1));
    step("tx_timeout", ev(SY, 1'b0, 1'b0, 1'b0, 1'b1));
    step("tx_to_1cyc", ev(SY));

    to_transmit(8'h00);
    #2;
    rst_n = 1'b0;
    m_xfer = 8'd0;
    #1;
    check("async_rst", obs(), ev(SY));
    @(negedge sample_clk);
    rst_n = 1'b1;
    bus.data_rx = 1'b1;
    for (int i = 0; i < 7; i++) step("requal", ev(SY));
    step("requal_done", ev(LI));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/n64_link_sequencer.md
N64_LINK_SEQUENCER -- requirements
Module: n64_link_sequencer

Interface
REQ-001 Parameter IDLE_CYCLES, default 8: consecutive high samples of data_rx required before the line is considered idle.
REQ-002 Parameter TURNAROUND_CYCLES, default 4: guard cycles between end of receive and start of transmit.
REQ-003 Parameter RX_TIMEOUT, default 1024: maximum cycles in RECEIVE before abort.
REQ-004 Parameter TX_TIMEOUT, default 1024: maximum cycles in TRANSMIT before abort.
REQ-005 sample_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 data_rx  in  1  sampled bus line, idle high.
REQ-008 tx_handoff  in  1  one-cycle pulse from the receiver: command, address and crc captured.
REQ-009 cmd  in  8  command byte from the receiver, valid in the tx_handoff cycle.
REQ-010 rx_handoff  in  1  one-cycle pulse from the transmitter: reply complete.
REQ-011 cur_operation  out  1  line direction; 0 = RX, 1 = TX.
REQ-012 tx_start  out  1  one-cycle pulse launching the transmitter.
REQ-013 rx_timeout  out  1  one-cycle pulse on receive abort.
REQ-014 tx_timeout  out  1  one-cycle pulse on transmit abort.
REQ-015 bad_cmd  out  1  one-cycle pulse on unsupported command.
REQ-016 state  out  3  current state encoding: SYNC=0, LISTEN=1, RECEIVE=2, TURNAROUND=3, TRANSMIT=4.
REQ-017 xfer_count  out  8  completed transactions, wraps 255 -> 0.

Function
REQ-018 SYNC: cur_operation=0; count consecutive data_rx=1 cycles; a 0 clears the count; reaching IDLE_CYCLES -> LISTEN.
REQ-019 LISTEN: cur_operation=0; data_rx=0 -> RECEIVE, and the timeout counter is cleared.
REQ-020 RECEIVE: cur_operation=0; timeout counter increments each cycle.
REQ-021 RECEIVE, tx_handoff=1 with cmd in {0x00, 0x01, 0xFF, 0x02, 0x03} -> TURNAROUND.
REQ-022 RECEIVE, tx_handoff=1 with any other cmd -> SYNC, and bad_cmd pulses in that same cycle's registered output (one cycle).
REQ-023 RECEIVE, counter reaches RX_TIMEOUT without tx_handoff -> SYNC, and rx_timeout pulses for one cycle.
REQ-024 tx_handoff and timeout in the same cycle: tx_handoff wins, and no timeout pulse is produced.
REQ-025 TURNAROUND: cur_operation=0; after exactly TURNAROUND_CYCLES cycles -> TRANSMIT.
REQ-026 TURNAROUND, TURNAROUND_CYCLES=0: go to TRANSMIT on the next cycle.
REQ-027 Entry to TRANSMIT: cur_operation=1 and tx_start=1 are asserted in the same cycle; tx_start is high for exactly one cycle.
REQ-028 TRANSMIT: cur_operation=1; timeout counter increments each cycle.
REQ-029 TRANSMIT, rx_handoff=1 -> SYNC, cur_operation=0 next cycle, and xfer_count increments.
REQ-030 TRANSMIT, counter reaches TX_TIMEOUT without rx_handoff -> SYNC, cur_operation=0, tx_timeout pulses, and xfer_count is unchanged.
REQ-031 rx_handoff and timeout in the same cycle: rx_handoff wins.
REQ-032 tx_handoff outside RECEIVE and rx_handoff outside TRANSMIT are ignored.
REQ-033 Data_rx activity in TURNAROUND or TRANSMIT is ignored.
REQ-034 Counters are 16 bits; the timeout counter saturates and never wraps.
REQ-035 All outputs are registered; there are no combinational input-to-output paths.

Reset
REQ-036 rst_n=0 immediately forces state=SYNC, cur_operation=0, tx_start=0, rx_timeout=0, tx_timeout=0, bad_cmd=0, xfer_count=0, and clears all counters.
REQ-037 Reset asserted mid-TRANSMIT returns the line to RX asynchronously, without waiting for a clock edge.
REQ-038 After release, the block re-qualifies line idle (IDLE_CYCLES high samples) before LISTEN.

Verification
REQ-039 Reset, data_rx high 8 cycles -> state=1 on cycle 8; a low at cycle 5 restarts the count.
REQ-040 LISTEN, data_rx low, tx_handoff with cmd=0x01 after 40 cycles -> TURNAROUND 4 cycles, then cur_operation=1 with a one-cycle tx_start.
REQ-041 TRANSMIT, rx_handoff after 100 cycles -> state=0, cur_operation=0, xfer_count 0->1; repeated 256 times -> xfer_count=0.
REQ-042 RECEIVE with no tx_handoff for 1024 cycles -> rx_timeout pulse, state=0; tx_handoff with cmd=0x55 -> bad_cmd pulse, no tx_start.
REQ-043 rx_handoff coincident with the TX_TIMEOUT cycle -> xfer_count increments, tx_timeout stays 0.
REQ-044 rst_n low while cur_operation=1 -> cur_operation=0 before the next sample_clk edge, all pulses 0.
